// File: rtl/imem_loader.sv
// Instruction-memory loader: takes a byte stream (16-bit word-count header, then
// big-endian program words) and writes each word at BASE_ADDR + 4*k, holding the CPU.
module imem_loader #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = '0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_DONE, S_ERROR
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [15:0] word_cnt_q, word_cnt_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [23:0] word_q, word_d;
  logic        in_ready_q, in_ready_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        cpu_hold_q, cpu_hold_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        accept;
  logic [15:0] hdr;

  assign accept = in_valid & in_ready_q;
  assign hdr    = {count_q[15:8], in_byte};

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    word_cnt_d  = word_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    word_d      = word_q;
    in_ready_d  = in_ready_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_hold_d  = cpu_hold_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    // Outputs are computed for the state being entered so every port comes from a flop.
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_LEN_HI;
          err_d      = 1'b0;
          cpu_hold_d = 1'b1;
          busy_d     = 1'b1;
          in_ready_d = 1'b1;
          byte_cnt_d = '0;
          word_cnt_d = '0;
          count_d    = '0;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          count_d[15:8] = in_byte;
          state_d       = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          count_d = hdr;
          if (hdr == 16'd0) begin
            state_d    = S_DONE;
            done_d     = 1'b1;
            in_ready_d = 1'b0;
          end else if (32'(hdr) > DEPTH_WORDS) begin
            state_d    = S_ERROR;
            err_d      = 1'b1;
            in_ready_d = 1'b0;
            cpu_hold_d = 1'b0;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          word_d     = {word_q[15:0], in_byte};
          if (byte_cnt_q == 2'd3) begin
            state_d     = S_WRITE;
            in_ready_d  = 1'b0;
            mem_we_d    = 1'b1;
            mem_wdata_d = {word_q, in_byte};
            mem_addr_d  = BASE_ADDR + (32'(word_cnt_q) << 2);
          end
        end
      end
      S_WRITE: begin
        word_cnt_d = word_cnt_q + 16'd1;
        if ((word_cnt_q + 16'd1) < count_q) begin
          state_d    = S_DATA;
          in_ready_d = 1'b1;
        end else begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_DONE: begin
        state_d    = S_IDLE;
        cpu_hold_d = 1'b0;
        busy_d     = 1'b0;
      end
      S_ERROR: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d    = S_IDLE;
        in_ready_d = 1'b0;
        cpu_hold_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      word_cnt_q  <= '0;
      byte_cnt_q  <= '0;
      word_q      <= '0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= BASE_ADDR;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      word_cnt_q  <= word_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      word_q      <= word_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_hold_q  <= cpu_hold_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_hold  = cpu_hold_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued by the stimulus,
// a negedge monitor pops and compares each mem_we pulse.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset, start, in_valid;
  logic [7:0]  in_byte;
  logic        in_ready, mem_we, cpu_hold, busy, done, err;
  logic [31:0] mem_addr, mem_wdata;

  int total = 0;
  int bad = 0;
  int done_count = 0;
  logic [63:0] exp_q[$];

  imem_loader #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare each write against the scoreboard queue.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", mem_addr, 32'hFFFF_FFFF);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("write_addr", mem_addr, e[63:32]);
        check("write_data", mem_wdata, e[31:0]);
      end
      check("ready_low_in_write", {31'd0, in_ready}, 32'd0);
      check("hold_in_write", {31'd0, cpu_hold}, 32'd1);
    end
    if (done === 1'b1) begin
      done_count++;
      check("hold_in_done", {31'd0, cpu_hold}, 32'd1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Present one byte and hold it until accepted; gap inserts an idle cycle after.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_byte  = b;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        tick();
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("byte_accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
    if (gap) tick();
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    logic [31:0] t;
    t = w;
    send_byte(t[31:24], gap);
    send_byte(t[23:16], gap);
    send_byte(t[15:8], gap);
    send_byte(t[7:0], gap);
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", {31'd0, seen}, 32'd1);
    @(negedge clk);
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("hold_released", {31'd0, cpu_hold}, 32'd0);
    check("busy_released", {31'd0, busy}, 32'd0);
  endtask

  logic [31:0] prog [4];

  initial begin
    prog[0] = 32'h2008_0001; prog[1] = 32'h2009_0002;
    prog[2] = 32'h0109_5020; prog[3] = 32'hAC0A_0000;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_byte = '0;
    tick(); tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_mem_we",   {31'd0, mem_we},   32'd0);
    check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd0);
    check("rst_busy",     {31'd0, busy},     32'd0);
    check("rst_done",     {31'd0, done},     32'd0);
    check("rst_err",      {31'd0, err},      32'd0);
    check("rst_addr",     mem_addr,          32'h0);
    check("rst_wdata",    mem_wdata,         32'h0);
    tick();

    // 1 and 2: four-word program, contiguous then with gaps.
    for (int pass = 0; pass < 2; pass++) begin
      pulse_start();
      check("hold_after_start", {31'd0, cpu_hold}, 32'd1);
      check("busy_after_start", {31'd0, busy}, 32'd1);
      send_byte(8'h00, pass == 1);
      send_byte(8'h04, pass == 1);
      for (int k = 0; k < 4; k++) begin
        exp_q.push_back({32'(k * 4), prog[k]});
        send_word(prog[k], pass == 1);
      end
      wait_done(10);
      check("err_after_load", {31'd0, err}, 32'd0);
    end

    // 3: empty load.
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    check("empty_done_now", {31'd0, done}, 32'd1);
    wait_done(1);
    check("empty_err", {31'd0, err}, 32'd0);

    // 4: oversize header, then recovery.
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h01, 1'b0);
    check("ovf_err", {31'd0, err}, 32'd1);
    check("ovf_ready", {31'd0, in_ready}, 32'd0);
    check("ovf_hold", {31'd0, cpu_hold}, 32'd0);
    in_valid = 1'b1; in_byte = 8'hAA;
    tick(); tick();
    check("ovf_err_sticky", {31'd0, err}, 32'd1);
    check("ovf_idle", {31'd0, busy}, 32'd0);
    check("ovf_not_consumed", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    pulse_start();
    check("err_cleared", {31'd0, err}, 32'd0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    exp_q.push_back({32'h0, 32'hDEAD_BEEF});
    send_word(32'hDEAD_BEEF, 1'b0);
    wait_done(10);

    // 5: full-depth load, word k = k.
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    for (int k = 0; k < 256; k++) begin
      exp_q.push_back({32'(k * 4), 32'(k)});
      send_word(32'(k), 1'b0);
    end
    wait_done(10);
    check("full_last_addr", mem_addr, 32'h3FC);
    check("full_last_data", mem_wdata, 32'h0000_00FF);

    // 6: ignored mid-load start, then reset after 2 bytes of word 1.
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    pulse_start();
    check("midstart_busy", {31'd0, busy}, 32'd1);
    exp_q.push_back({32'h0, 32'h1122_3344});
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_ready", {31'd0, in_ready}, 32'd0);
    check("mid_rst_we",    {31'd0, mem_we},   32'd0);
    check("mid_rst_hold",  {31'd0, cpu_hold}, 32'd0);
    check("mid_rst_busy",  {31'd0, busy},     32'd0);
    check("mid_rst_done",  {31'd0, done},     32'd0);
    check("mid_rst_err",   {31'd0, err},      32'd0);
    check("mid_rst_addr",  mem_addr,          32'h0);
    check("mid_rst_wdata", mem_wdata,         32'h0);
    tick();
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    exp_q.push_back({32'h0, 32'h1234_5678});
    send_word(32'h1234_5678, 1'b0);
    wait_done(10);

    tick(); tick();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("done_pulses", 32'(done_count), 32'd6);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
